uart_rx_param: RTL and testbench
================================

Name: uart_rx_param

Overview:
Parametrised UART receiver, the successor to the fixed 8-bit/9600-baud receiver. It supports configurable data width, bit period and parity mode. Sampling is mid-bit from a synchronised line, with start-bit glitch rejection. Received words are held behind a valid/ack handshake, with framing, parity and overrun reporting. It sits between the board Rx pin and any byte-consuming logic on the system clock.

Parameters:
CLKS_PER_BIT, 5208, system clocks per bit period (50 MHz / 9600 baud); must be >= 4
DATA_BITS, 8, data bits per frame, 5..9
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, stop bits checked, 1 or 2

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  synchronous active-low reset
rx  input  1  asynchronous serial line, idle high
data  output  DATA_BITS  last received word, LSB = first bit on line
valid  output  1  word in data is unread
ack  input  1  consumer accepts word; meaningful only while valid=1
frame_err  output  1  a stop bit was sampled 0 for the word in data
parity_err  output  1  parity mismatch for the word in data (always 0 when PARITY=0)
overrun  output  1  a word completed while the previous one was still unread
busy  output  1  FSM not in IDLE

Behaviour:
- Reset (rst_n=0 at a clk edge): all outputs go to 0, FSM goes to IDLE, counters are cleared, and both synchroniser flops are set to 1.
- rx passes through a 2-flop synchroniser; rxs denotes the second flop. The line-to-FSM latency is 2 clocks.
- Bit counter bc counts 0..CLKS_PER_BIT-1; HALF = CLKS_PER_BIT/2 (integer division).
- FSM states: IDLE, START, DATA, PAR, STOP.
- IDLE: rxs=0 -> START, bc=0.
- START: at bc=HALF-1, rxs=0 -> DATA, bc=0, bit index=0. If rxs=1 at that point, it is a glitch: return to IDLE with no flags changed.
- DATA: at bc=CLKS_PER_BIT-1, shift rxs into the shift register, LSB first. After DATA_BITS samples go to PAR if PARITY!=0, else to STOP.
- PAR: sample one bit at bc=CLKS_PER_BIT-1. Odd mode requires the XOR of data and parity bit to be 1; even mode requires it to be 0.
- STOP: sample STOP_BITS bits at bc=CLKS_PER_BIT-1. Any 0 sample marks a frame error. After the last stop sample, complete the frame and go to IDLE in the same cycle, so start detection resumes mid-stop-bit.
- Frame completion (one clock): load data, frame_err and parity_err; set valid=1. Data is written even when errors are present.
- Overrun: if valid=1 and ack=0 in the completion cycle, overrun is set and data is overwritten with the new word. overrun is sticky and clears only on an accepted ack.
- Handshake: valid=1 and ack=1 clears valid and overrun on the next edge. ack while valid=0 is ignored.
- Ack in the same cycle as completion: the new word loads, valid stays 1, and overrun is not set.
- busy=1 in every state except IDLE.
- Reset mid-frame: the frame is discarded and no valid is produced.

Test Plan:
- CLKS_PER_BIT=16, PARITY=0: send 0xA5 (8N1) -> valid rises exactly once, 16*9+HALF+2 clocks after the start edge; data=0xA5; frame_err=0, parity_err=0.
- Hold ack=1 for one clock after valid -> valid=0 on the next edge; then send 0x3C -> data=0x3C, overrun=0.
- Send 0x11 then 0x22 with no ack -> data=0x22, valid=1, overrun=1. A single ack clears both valid and overrun.
- Send a 3-clock low glitch on rx (less than HALF=8) -> FSM returns to IDLE, no valid, busy pulses then returns to 0.
- PARITY=2: send 0x07 with parity bit 1 -> parity_err=0. Repeat with parity bit 0 -> parity_err=1 and data=0x07. Send a frame with stop bit 0 -> frame_err=1.
- Pull rst_n low during the DATA state of 0xFF, then release and send 0x5A -> only one valid, data=0x5A, all error flags 0.

Source files
------------

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 2-flop synchronised line, mid-bit sampling, start-glitch rejection,
// word held behind valid/ack with framing, parity and sticky overrun flags.
module uart_rx_param #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  input  logic                 ack,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int BCW  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BCW-1:0] BC_HALF = BCW'(HALF - 1);
  localparam logic [BCW-1:0] BC_LAST = BCW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]     IDX_DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]     IDX_STOP_LAST = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  state_t               state;
  logic [1:0]           sync;
  logic [BCW-1:0]       bc;
  logic [3:0]           idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit;
  logic                 fe_acc;
  logic                 par_bad;
  logic                 rxs;

  assign rxs  = sync[1];
  assign busy = (state != IDLE);

  always_comb begin
    par_bad = 1'b0;
    if (PARITY == 1)      par_bad = ~(^shreg ^ par_bit);
    else if (PARITY == 2) par_bad = ^shreg ^ par_bit;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync       <= 2'b11;
      state      <= IDLE;
      bc         <= '0;
      idx        <= '0;
      shreg      <= '0;
      par_bit    <= 1'b0;
      fe_acc     <= 1'b0;
      data       <= '0;
      valid      <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      sync <= {sync[0], rx};

      // Accepted ack; a completion in this same cycle overrides below.
      if (valid && ack) begin
        valid   <= 1'b0;
        overrun <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (!rxs) begin
            state <= START;
            bc    <= '0;
          end
        end
        START: begin
          if (bc == BC_HALF) begin
            bc <= '0;
            if (!rxs) begin
              state  <= DATA;
              idx    <= '0;
              fe_acc <= 1'b0;
            end else begin
              state <= IDLE;
            end
          end else begin
            bc <= bc + 1'b1;
          end
        end
        DATA: begin
          if (bc == BC_LAST) begin
            bc    <= '0;
            shreg <= {rxs, shreg[DATA_BITS-1:1]};
            if (idx == IDX_DATA_LAST) begin
              idx   <= '0;
              state <= (PARITY != 0) ? PAR : STOP;
            end else begin
              idx <= idx + 4'd1;
            end
          end else begin
            bc <= bc + 1'b1;
          end
        end
        PAR: begin
          if (bc == BC_LAST) begin
            bc      <= '0;
            par_bit <= rxs;
            state   <= STOP;
          end else begin
            bc <= bc + 1'b1;
          end
        end
        STOP: begin
          if (bc == BC_LAST) begin
            bc <= '0;
            if (idx == IDX_STOP_LAST) begin
              // Back to IDLE mid-stop-bit so a following start edge is not missed.
              state      <= IDLE;
              idx        <= '0;
              data       <= shreg;
              frame_err  <= fe_acc | ~rxs;
              parity_err <= par_bad;
              valid      <= 1'b1;
              if (valid) overrun <= ~ack;
            end else begin
              fe_acc <= fe_acc | ~rxs;
              idx    <= idx + 4'd1;
            end
          end else begin
            bc <= bc + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: two instances (8N1 and 8E1) checked every cycle against a frame-level model.
module tb_uart_rx_param;

  localparam int CPB  = 16;
  localparam int HALF = CPB / 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] rx, ack;
  logic [7:0] dat [2];
  logic [1:0] vld, fe, pe, ov, bsy;

  always #5 clk = ~clk;

  uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_none (
    .clk(clk), .rst_n(rst_n), .rx(rx[0]), .data(dat[0]), .valid(vld[0]), .ack(ack[0]),
    .frame_err(fe[0]), .parity_err(pe[0]), .overrun(ov[0]), .busy(bsy[0]));

  uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_even (
    .clk(clk), .rst_n(rst_n), .rx(rx[1]), .data(dat[1]), .valid(vld[1]), .ack(ack[1]),
    .frame_err(fe[1]), .parity_err(pe[1]), .overrun(ov[1]), .busy(bsy[1]));

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Frame-level model: the stimulus announces each frame's outcome and its
  // completion edge (start edge + sync + half bit + one bit period per sampled bit).
  int         ecount = 0;
  logic [1:0] p_on = 2'b00, p_gl = 2'b00, p_fe = 2'b00, p_pe = 2'b00;
  int         p_bs [2];
  int         p_t  [2];
  logic [7:0] p_d  [2];
  logic [1:0] m_vld = 2'b00, m_fe = 2'b00, m_pe = 2'b00, m_ov = 2'b00, m_busy = 2'b00;
  logic [7:0] m_dat [2] = '{8'h00, 8'h00};

  always @(posedge clk) begin
    ecount <= ecount + 1;
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        m_vld[i] <= 1'b0; m_fe[i] <= 1'b0; m_pe[i] <= 1'b0; m_ov[i] <= 1'b0;
        m_busy[i] <= 1'b0; m_dat[i] <= 8'h00; p_on[i] <= 1'b0;
      end else begin
        if (p_on[i] && ecount + 1 == p_bs[i]) m_busy[i] <= 1'b1;
        if (p_on[i] && ecount + 1 == p_t[i]) begin
          m_busy[i] <= 1'b0;
          p_on[i]   <= 1'b0;
          if (!p_gl[i]) begin
            m_dat[i] <= p_d[i];
            m_fe[i]  <= p_fe[i];
            m_pe[i]  <= p_pe[i];
            m_vld[i] <= 1'b1;
            if (m_vld[i]) m_ov[i] <= !ack[i];
          end else if (m_vld[i] && ack[i]) begin
            m_vld[i] <= 1'b0;
            m_ov[i]  <= 1'b0;
          end
        end else if (m_vld[i] && ack[i]) begin
          m_vld[i] <= 1'b0;
          m_ov[i]  <= 1'b0;
        end
      end
    end
  end

  int         rises [2] = '{0, 0};
  int         rise_e [2] = '{0, 0};
  logic [1:0] prev_v = 2'b00;
  logic [1:0] bsy_seen = 2'b00;

  always @(negedge clk) begin
    if (ecount >= 1) begin
      for (int i = 0; i < 2; i++) begin
        check($sformatf("valid%0d", i),      vld[i], m_vld[i]);
        check($sformatf("data%0d", i),       dat[i], m_dat[i]);
        check($sformatf("frame_err%0d", i),  fe[i],  m_fe[i]);
        check($sformatf("parity_err%0d", i), pe[i],  m_pe[i]);
        check($sformatf("overrun%0d", i),    ov[i],  m_ov[i]);
        check($sformatf("busy%0d", i),       bsy[i], m_busy[i]);
        if (vld[i] === 1'b1 && prev_v[i] !== 1'b1) begin
          rises[i]++;
          rise_e[i] = ecount;
        end
        prev_v[i] = vld[i];
        if (bsy[i] === 1'b1) bsy_seen[i] = 1'b1;
      end
    end
  end

  task automatic hold(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int last_e0 [2];

  task automatic send(input int i, input logic [7:0] w, input logic pbit, input logic stopv);
    int nb;
    nb = (i == 1) ? 10 : 9;
    @(posedge clk); #1;
    last_e0[i] = ecount;
    p_bs[i] = ecount + 3;
    p_t[i]  = ecount + 3 + HALF + CPB * nb;
    p_d[i]  = w;
    p_fe[i] = !stopv;
    p_pe[i] = (i == 1) ? ((^w) ^ pbit) : 1'b0;
    p_gl[i] = 1'b0;
    p_on[i] = 1'b1;
    rx[i] = 1'b0; hold(CPB);
    for (int b = 0; b < 8; b++) begin
      rx[i] = w[b]; hold(CPB);
    end
    if (i == 1) begin
      rx[i] = pbit; hold(CPB);
    end
    rx[i] = stopv;
    if (stopv) hold(CPB);
    else begin
      hold(HALF + 1);
      rx[i] = 1'b1;
      hold(CPB - HALF - 1);
    end
    rx[i] = 1'b1;
    hold(4);
  endtask

  task automatic ack_pulse(input int i);
    ack[i] = 1'b1; hold(1);
    ack[i] = 1'b0; hold(1);
  endtask

  int r0;

  initial begin
    rst_n = 1'b0; rx = 2'b11; ack = 2'b00;
    hold(3);
    rst_n = 1'b1;
    check("reset_valid", vld, 2'b00);
    check("reset_busy", bsy, 2'b00);
    check("reset_overrun", ov, 2'b00);
    check("reset_data", dat[0], 8'h00);
    hold(5);

    // 8N1 0xA5: single rise, fixed latency from first sampled start edge
    send(0, 8'hA5, 1'b0, 1'b1);
    check("a5_rises", rises[0], 1);
    check("a5_latency", rise_e[0] - (last_e0[0] + 1), 154);
    check("a5_data", dat[0], 8'hA5);
    check("a5_errs", {fe[0], pe[0]}, 2'b00);

    ack_pulse(0);
    check("ack_clears_valid", vld[0], 1'b0);
    send(0, 8'h3C, 1'b0, 1'b1);
    check("3c_data", dat[0], 8'h3C);
    check("3c_overrun", ov[0], 1'b0);
    ack_pulse(0);

    send(0, 8'h11, 1'b0, 1'b1);
    send(0, 8'h22, 1'b0, 1'b1);
    check("ovr_data", dat[0], 8'h22);
    check("ovr_flags", {vld[0], ov[0]}, 2'b11);
    ack_pulse(0);
    check("ovr_cleared", {vld[0], ov[0]}, 2'b00);

    // 3-clock start glitch
    r0 = rises[0];
    bsy_seen[0] = 1'b0;
    @(posedge clk); #1;
    p_bs[0] = ecount + 3; p_t[0] = ecount + 3 + HALF; p_gl[0] = 1'b1; p_on[0] = 1'b1;
    rx[0] = 1'b0; hold(3);
    rx[0] = 1'b1; hold(30);
    check("glitch_no_valid", rises[0], r0);
    check("glitch_busy_pulsed", bsy_seen[0], 1'b1);
    check("glitch_busy_idle", bsy[0], 1'b0);

    // even parity instance
    send(1, 8'h07, 1'b1, 1'b1);
    check("par_ok", pe[1], 1'b0);
    ack_pulse(1);
    send(1, 8'h07, 1'b0, 1'b1);
    check("par_bad", pe[1], 1'b1);
    check("par_bad_data", dat[1], 8'h07);
    ack_pulse(1);
    send(1, 8'h5A, 1'b0, 1'b0);
    check("stop_low_fe", fe[1], 1'b1);
    check("stop_low_pe", pe[1], 1'b0);
    ack_pulse(1);

    // reset in the middle of 0xFF
    r0 = rises[0];
    @(posedge clk); #1;
    p_bs[0] = ecount + 3; p_t[0] = ecount + 100000; p_gl[0] = 1'b1; p_on[0] = 1'b1;
    rx[0] = 1'b0; hold(CPB);
    rx[0] = 1'b1; hold(CPB + HALF);
    check("rst_mid_busy", bsy[0], 1'b1);
    rst_n = 1'b0; hold(2);
    rst_n = 1'b1; hold(CPB * 9);
    send(0, 8'h5A, 1'b0, 1'b1);
    check("rst_one_valid", rises[0] - r0, 1);
    check("rst_data", dat[0], 8'h5A);
    check("rst_flags", {fe[0], pe[0], ov[0]}, 3'b000);

    hold(5);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
